// File: rtl/k423_wb_stage.sv
// k423 write-back stage: accepts EX results, collects and formats load data,
// writes the register file, issues redirects and counts retired instructions.
module k423_wb_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RIDX_W      = 5,
  parameter int unsigned LS_SIZE_W   = 2,
  parameter int unsigned LD_TIMEOUT  = 64,
  parameter logic [63:0] INSTRET_RST = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex2wb_stage_vld_i,
  output logic                 wb_stage_rdy_o,
  input  logic [ADDR_W-1:0]    wb_pc_i,
  input  logic                 wb_rd_vld_i,
  input  logic [RIDX_W-1:0]    wb_rd_idx_i,
  input  logic [XLEN-1:0]      wb_rd_i,
  input  logic                 wb_rd_load_i,
  input  logic [LS_SIZE_W-1:0] wb_rd_load_size_i,
  input  logic                 wb_rd_load_unsigned_i,
  input  logic [ADDR_W-1:0]    wb_rd_load_addr_i,
  input  logic                 wb_excp_br_tkn_i,
  input  logic [XLEN-1:0]      wb_excp_br_pc_i,
  input  logic                 wb_bju_br_tkn_i,
  input  logic [XLEN-1:0]      wb_bju_br_pc_i,
  input  logic                 dmem_rsp_vld_i,
  input  logic [XLEN-1:0]      dmem_rsp_data_i,
  input  logic                 dmem_rsp_err_i,
  output logic                 rf_wr_en_o,
  output logic [RIDX_W-1:0]    rf_wr_idx_o,
  output logic [XLEN-1:0]      rf_wr_data_o,
  output logic                 redirect_vld_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  output logic                 retire_vld_o,
  output logic [ADDR_W-1:0]    retire_pc_o,
  output logic                 load_err_o,
  output logic [63:0]          instret_o
);

  localparam int unsigned    CNT_W    = $clog2(LD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      instret_q;

  logic [XLEN-1:0]  rsp_shifted;
  logic [XLEN-1:0]  load_data;
  logic             misalign;
  logic             timeout;
  logic             complete;
  logic             cpl_err;
  logic             cpl_ok;
  logic             rdy;

  // Only the byte offset of the load address matters here.
  logic unused_addr_hi;
  assign unused_addr_hi = ^wb_rd_load_addr_i[ADDR_W-1:2];

  assign rsp_shifted = dmem_rsp_data_i >> {wb_rd_load_addr_i[1:0], 3'b000};
  assign timeout     = (cnt_q == CNT_LAST);

  // Misaligned half/word and reserved sizes fail without touching memory.
  always_comb begin
    misalign = 1'b0;
    if (wb_rd_load_size_i == LS_SIZE_W'(1))
      misalign = wb_rd_load_addr_i[0];
    else if (wb_rd_load_size_i == LS_SIZE_W'(2))
      misalign = (wb_rd_load_addr_i[1:0] != 2'b00);
    else if (wb_rd_load_size_i > LS_SIZE_W'(2))
      misalign = 1'b1;
  end

  // Extract byte/half from the shifted response word and extend it.
  always_comb begin
    load_data = rsp_shifted;
    if (wb_rd_load_size_i == LS_SIZE_W'(0))
      load_data = wb_rd_load_unsigned_i ? {{(XLEN-8){1'b0}}, rsp_shifted[7:0]}
                                        : {{(XLEN-8){rsp_shifted[7]}}, rsp_shifted[7:0]};
    else if (wb_rd_load_size_i == LS_SIZE_W'(1))
      load_data = wb_rd_load_unsigned_i ? {{(XLEN-16){1'b0}}, rsp_shifted[15:0]}
                                        : {{(XLEN-16){rsp_shifted[15]}}, rsp_shifted[15:0]};
  end

  // Next-state, timeout counter and completion decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    cpl_err  = 1'b0;
    rdy      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (ex2wb_stage_vld_i) begin
          if (!wb_rd_load_i) begin
            complete = 1'b1;
          end else if (misalign) begin
            complete = 1'b1;
            cpl_err  = 1'b1;
          end else if (dmem_rsp_vld_i) begin
            complete = 1'b1;
            cpl_err  = dmem_rsp_err_i;
          end else begin
            rdy     = 1'b0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        rdy   = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (!ex2wb_stage_vld_i) begin
          // Pipeline clear: a response or timeout landing in the same cycle
          // closes the load right here, otherwise drain the stale response.
          if (dmem_rsp_vld_i || timeout) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (dmem_rsp_vld_i) begin
          complete = 1'b1;
          cpl_err  = dmem_rsp_err_i;
          rdy      = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else if (timeout) begin
          complete = 1'b1;
          cpl_err  = 1'b1;
          rdy      = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end
      end
      S_DRAIN: begin
        rdy   = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (dmem_rsp_vld_i || timeout) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign cpl_ok = complete && !cpl_err;

  // Output drive; everything is held inactive while in reset.
  always_comb begin
    wb_stage_rdy_o = 1'b1;
    rf_wr_en_o     = 1'b0;
    rf_wr_idx_o    = '0;
    rf_wr_data_o   = '0;
    redirect_vld_o = 1'b0;
    redirect_pc_o  = '0;
    retire_vld_o   = 1'b0;
    retire_pc_o    = '0;
    load_err_o     = 1'b0;
    if (!rst_i) begin
      wb_stage_rdy_o = rdy;
      rf_wr_en_o     = cpl_ok && wb_rd_vld_i && (wb_rd_idx_i != '0);
      rf_wr_idx_o    = wb_rd_idx_i;
      rf_wr_data_o   = wb_rd_load_i ? load_data : wb_rd_i;
      redirect_vld_o = cpl_ok && (wb_excp_br_tkn_i || wb_bju_br_tkn_i);
      redirect_pc_o  = wb_excp_br_tkn_i ? wb_excp_br_pc_i : wb_bju_br_pc_i;
      retire_vld_o   = complete;
      retire_pc_o    = wb_pc_i;
      load_err_o     = complete && cpl_err;
    end
  end

  // State, timeout counter and retired-instruction counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      instret_q <= INSTRET_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cpl_ok)
        instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_o = instret_q;

endmodule

// File: tb/tb_k423_wb_stage.sv
// Directed bench for k423_wb_stage with a retirement scoreboard.
module tb_k423_wb_stage;

  logic        clk = 1'b0;
  logic        rst, vld, rd_vld, ld, ld_uns, excp, bju, rsp_vld, rsp_err;
  logic [31:0] pc, rd, ld_addr, excp_pc, bju_pc, rsp_data;
  logic [4:0]  rd_idx;
  logic [1:0]  ld_size;

  logic        rdy, wr_en, redir_vld, ret_vld, ld_err;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data, redir_pc, ret_pc;
  logic [63:0] instret;

  logic        rdy_b, wr_en_b, redir_vld_b, ret_vld_b, ld_err_b;
  logic [4:0]  wr_idx_b;
  logic [31:0] wr_data_b, redir_pc_b, ret_pc_b;
  logic [63:0] instret_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        wr;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  k423_wb_stage #(
    .XLEN(32), .ADDR_W(32), .RIDX_W(5), .LS_SIZE_W(2), .LD_TIMEOUT(64)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ex2wb_stage_vld_i(vld), .wb_stage_rdy_o(rdy),
    .wb_pc_i(pc), .wb_rd_vld_i(rd_vld), .wb_rd_idx_i(rd_idx), .wb_rd_i(rd),
    .wb_rd_load_i(ld), .wb_rd_load_size_i(ld_size), .wb_rd_load_unsigned_i(ld_uns),
    .wb_rd_load_addr_i(ld_addr), .wb_excp_br_tkn_i(excp), .wb_excp_br_pc_i(excp_pc),
    .wb_bju_br_tkn_i(bju), .wb_bju_br_pc_i(bju_pc), .dmem_rsp_vld_i(rsp_vld),
    .dmem_rsp_data_i(rsp_data), .dmem_rsp_err_i(rsp_err), .rf_wr_en_o(wr_en),
    .rf_wr_idx_o(wr_idx), .rf_wr_data_o(wr_data), .redirect_vld_o(redir_vld),
    .redirect_pc_o(redir_pc), .retire_vld_o(ret_vld), .retire_pc_o(ret_pc),
    .load_err_o(ld_err), .instret_o(instret)
  );

  // Second copy with the counter preloaded to all ones to exercise the wrap.
  k423_wb_stage #(
    .XLEN(32), .ADDR_W(32), .RIDX_W(5), .LS_SIZE_W(2), .LD_TIMEOUT(64),
    .INSTRET_RST(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut_wrap (
    .clk_i(clk), .rst_i(rst), .ex2wb_stage_vld_i(vld), .wb_stage_rdy_o(rdy_b),
    .wb_pc_i(pc), .wb_rd_vld_i(rd_vld), .wb_rd_idx_i(rd_idx), .wb_rd_i(rd),
    .wb_rd_load_i(ld), .wb_rd_load_size_i(ld_size), .wb_rd_load_unsigned_i(ld_uns),
    .wb_rd_load_addr_i(ld_addr), .wb_excp_br_tkn_i(excp), .wb_excp_br_pc_i(excp_pc),
    .wb_bju_br_tkn_i(bju), .wb_bju_br_pc_i(bju_pc), .dmem_rsp_vld_i(rsp_vld),
    .dmem_rsp_data_i(rsp_data), .dmem_rsp_err_i(rsp_err), .rf_wr_en_o(wr_en_b),
    .rf_wr_idx_o(wr_idx_b), .rf_wr_data_o(wr_data_b), .redirect_vld_o(redir_vld_b),
    .redirect_pc_o(redir_pc_b), .retire_vld_o(ret_vld_b), .retire_pc_o(ret_pc_b),
    .load_err_o(ld_err_b), .instret_o(instret_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compares the retirement outputs against the oldest expected record.
  task automatic sb_check(input string tag, input logic exp_retire);
    exp_t e;
    chk({tag, "_retire"}, ret_vld, exp_retire);
    if (ret_vld === 1'b1) begin
      n_checks++;
      assert (sb_q.size() != 0) else begin
        n_errors++;
        $error("FAIL %s_sb_empty: observed retire expected no pending entry", tag);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({tag, "_pc"}, ret_pc, e.pc);
        chk({tag, "_wr_en"}, wr_en, e.wr);
        chk({tag, "_load_err"}, ld_err, e.err);
        if (e.wr) begin
          chk({tag, "_wr_idx"}, wr_idx, e.idx);
          chk({tag, "_wr_data"}, wr_data, e.data);
        end
      end
    end
  endtask

  task automatic push(input logic [31:0] p, input logic w, input logic [4:0] i,
                      input logic [31:0] d, input logic er);
    exp_t e;
    e.pc = p; e.wr = w; e.idx = i; e.data = d; e.err = er;
    sb_q.push_back(e);
  endtask

  task automatic clr();
    vld = 0; pc = '0; rd_vld = 0; rd_idx = '0; rd = '0; ld = 0; ld_size = '0;
    ld_uns = 0; ld_addr = '0; excp = 0; excp_pc = '0; bju = 0; bju_pc = '0;
    rsp_vld = 0; rsp_data = '0; rsp_err = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  waited;
    bit  seen;
    waited = 0;
    seen   = 0;

    // Reset with active-looking inputs: everything must stay quiet
    clr(); rst = 1; vld = 1; rd_vld = 1; rd_idx = 5; rd = 32'h1234; excp = 1;
    rsp_vld = 1;
    cyc(); cyc(); #1;
    chk("rst_rdy", rdy, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_redirect", redir_vld, 0);
    chk("rst_retire", ret_vld, 0);
    chk("rst_load_err", ld_err, 0);
    chk("rst_instret", instret, 0);
    chk("rst_instret_pre", instret_b, 64'hFFFF_FFFF_FFFF_FFFF);

    // Stray response in IDLE is ignored
    cyc(); rst = 0; clr(); rsp_vld = 1; rsp_data = 32'hFFFF_FFFF; #1;
    chk("idle_rdy", rdy, 1);
    sb_check("idle_rsp", 0);

    // ALU op to x5
    cyc(); clr(); vld = 1; pc = 32'h100; rd_vld = 1; rd_idx = 5; rd = 32'hDEADBEEF;
    push(32'h100, 1, 5, 32'hDEADBEEF, 0); #1;
    chk("alu_rdy", rdy, 1);
    sb_check("alu", 1);

    // ALU op to x0: retired, no write
    cyc(); clr(); vld = 1; pc = 32'h104; rd_vld = 1; rd_idx = 0; rd = 32'h55;
    push(32'h104, 0, 0, 0, 0); #1;
    chk("instret_1", instret, 1);
    chk("instret_wrap", instret_b, 0);
    sb_check("alu_x0", 1);

    // Signed byte load at 0x1003, response three cycles later
    cyc(); clr(); vld = 1; pc = 32'h108; ld = 1; ld_size = 0; ld_addr = 32'h1003;
    rd_vld = 1; rd_idx = 7;
    push(32'h108, 1, 7, 32'hFFFF_FF80, 0); #1;
    chk("instret_2", instret, 2);
    chk("lb_rdy0", rdy, 0);
    sb_check("lb_issue", 0);
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("lb_wait_rdy", rdy, 0);
      sb_check("lb_wait", 0);
    end
    cyc(); rsp_vld = 1; rsp_data = 32'h8011_2233; #1;
    chk("lb_rsp_rdy", rdy, 1);
    sb_check("lb", 1);

    // Unsigned half load at 0x1002 with same-cycle response
    cyc(); clr(); vld = 1; pc = 32'h10C; ld = 1; ld_size = 1; ld_uns = 1;
    ld_addr = 32'h1002; rd_vld = 1; rd_idx = 8; rsp_vld = 1; rsp_data = 32'h8011_2233;
    push(32'h10C, 1, 8, 32'h0000_8011, 0); #1;
    chk("instret_3", instret, 3);
    chk("lhu_rdy", rdy, 1);
    sb_check("lhu", 1);

    // Exception and branch both taken: exception wins
    cyc(); clr(); vld = 1; pc = 32'h110; excp = 1; excp_pc = 32'h200;
    bju = 1; bju_pc = 32'h100;
    push(32'h110, 0, 0, 0, 0); #1;
    chk("instret_4", instret, 4);
    chk("excp_redir_vld", redir_vld, 1);
    chk("excp_redir_pc", redir_pc, 32'h200);
    sb_check("excp", 1);

    // Branch only
    cyc(); clr(); vld = 1; pc = 32'h114; bju = 1; bju_pc = 32'h100;
    push(32'h114, 0, 0, 0, 0); #1;
    chk("bju_redir_vld", redir_vld, 1);
    chk("bju_redir_pc", redir_pc, 32'h100);
    sb_check("bju", 1);

    cyc(); clr(); #1;
    chk("redir_gone", redir_vld, 0);
    chk("instret_6", instret, 6);
    sb_check("bubble", 0);

    // Load with no response: times out after 64 WAIT cycles
    cyc(); clr(); vld = 1; pc = 32'h118; ld = 1; ld_size = 2; ld_addr = 32'h2000;
    rd_vld = 1; rd_idx = 9;
    push(32'h118, 0, 9, 0, 1); #1;
    sb_check("to_issue", 0);
    while (!seen && waited < 100) begin
      cyc(); waited++; #1;
      if (ret_vld === 1'b1) seen = 1;
    end
    chk("to_seen", seen, 1);
    chk("to_cycles", waited, 64);
    chk("to_rdy", rdy, 1);
    sb_check("to", 1);
    cyc(); clr(); #1;
    chk("to_instret", instret, 6);
    chk("to_idle_rdy", rdy, 1);

    // Pipeline clear while waiting, then a normal load
    cyc(); clr(); vld = 1; pc = 32'h11C; ld = 1; ld_size = 0; ld_addr = 32'h3000;
    rd_vld = 1; rd_idx = 10; #1;
    chk("pc_c0_rdy", rdy, 0);
    cyc(); #1;
    chk("pc_c1_rdy", rdy, 0);
    cyc(); vld = 0; #1;
    chk("pc_c2_rdy", rdy, 0);
    sb_check("pc_c2", 0);
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("pc_drain_rdy", rdy, 0);
    end
    cyc(); rsp_vld = 1; rsp_data = 32'hFFFF_FFFF; #1;
    chk("pc_c5_rdy", rdy, 0);
    chk("pc_c5_wr_en", wr_en, 0);
    sb_check("pc_c5", 0);
    cyc(); clr(); #1;
    chk("pc_c6_rdy", rdy, 1);
    cyc(); clr(); vld = 1; pc = 32'h120; ld = 1; ld_size = 0; ld_uns = 1;
    ld_addr = 32'h3001; rd_vld = 1; rd_idx = 11;
    push(32'h120, 1, 11, 32'h0000_00A5, 0); #1;
    chk("pc_next_rdy0", rdy, 0);
    sb_check("pc_next_issue", 0);
    cyc(); rsp_vld = 1; rsp_data = 32'h0000_A500; #1;
    sb_check("pc_next", 1);

    // Misaligned word load: immediate error
    cyc(); clr(); vld = 1; pc = 32'h124; ld = 1; ld_size = 2; ld_addr = 32'h1001;
    rd_vld = 1; rd_idx = 12;
    push(32'h124, 0, 12, 0, 1); #1;
    chk("instret_7", instret, 7);
    chk("mis_rdy", rdy, 1);
    chk("mis_redir", redir_vld, 0);
    sb_check("mis", 1);

    // Reserved size 3: immediate error
    cyc(); clr(); vld = 1; pc = 32'h128; ld = 1; ld_size = 3; ld_addr = 32'h1000;
    rd_vld = 1; rd_idx = 13;
    push(32'h128, 0, 13, 0, 1); #1;
    sb_check("sz3", 1);

    // Bus error response, with an exception that must not redirect
    cyc(); clr(); vld = 1; pc = 32'h12C; ld = 1; ld_size = 2; ld_addr = 32'h1000;
    rd_vld = 1; rd_idx = 14; rsp_vld = 1; rsp_err = 1; excp = 1; excp_pc = 32'h300;
    push(32'h12C, 0, 14, 0, 1); #1;
    chk("berr_redir", redir_vld, 0);
    sb_check("berr", 1);

    cyc(); clr(); #1;
    chk("err_instret", instret, 7);

    // Reset in the middle of a load abandons it
    cyc(); clr(); vld = 1; pc = 32'h130; ld = 1; ld_addr = 32'h1000;
    rd_vld = 1; rd_idx = 15; #1;
    cyc(); rst = 1; rsp_vld = 1; rsp_data = 32'h1; #1;
    chk("rstld_wr_en", wr_en, 0);
    chk("rstld_rdy", rdy, 1);
    sb_check("rstld", 0);
    cyc(); rst = 0; clr(); #1;
    chk("rstld_instret", instret, 0);
    chk("rstld_idle_rdy", rdy, 1);

    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
